// File: rtl/ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_kbd_rx
//  Description : PS/2 keyboard receiver. Deserialises device-to-host frames,
//                checks parity/stop, reports every byte and tracks make/break
//                sequences to drive a held-key value plus load strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_kbd_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] scan_o,
    output logic       scan_valid_o,
    output logic       frame_err_o,
    output logic [7:0] key_o,
    output logic       key_load_o,
    output logic       busy_o
);

    localparam int                 c_tmo_w   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_lim = c_tmo_w'(TIMEOUT_CYCLES);
    localparam logic [7:0]         c_ext     = 8'hE0;
    localparam logic [7:0]         c_brk     = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;
    logic                   w_clk_s;
    logic                   w_data_s;
    logic                   w_fall;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic                   r_parity;
    logic [c_tmo_w-1:0]     r_tmo;
    logic                   w_timeout;
    logic                   w_good;
    logic                   w_bad;

    logic [7:0]             r_scan;
    logic                   r_scan_valid;
    logic                   r_frame_err;
    logic [7:0]             r_key;
    logic                   r_key_load;
    logic [7:0]             r_held;
    logic                   r_ext_pend;
    logic                   r_brk_pend;

    assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
    assign w_data_s = r_data_sync[SYNC_STAGES-1];
    assign w_fall   = r_clk_prev & ~w_clk_s;

    // Synchronise the asynchronous pins; idle-high reset avoids a false edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk_i};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data_i};
            r_clk_prev  <= w_clk_s;
        end
    end

    // Timeout fires only when no edge arrives in the same cycle.
    assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_tmo == c_tmo_lim);

    // Frame state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and frame verdict on the stop-bit edge or timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_good      = 1'b0;
        w_bad       = 1'b0;
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_bad       = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE:   if (!w_data_s) w_state_nxt = S_DATA;
                S_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
                S_PARITY: w_state_nxt = S_STOP;
                S_STOP: begin
                    w_state_nxt = S_IDLE;
                    if (w_data_s && (^{r_shift, r_parity})) w_good = 1'b1;
                    else                                    w_bad  = 1'b1;
                end
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Bit capture and inter-edge timeout counter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_parity  <= 1'b0;
            r_tmo     <= '0;
        end else begin
            if (w_fall || (r_state == S_IDLE) || w_timeout) r_tmo <= '0;
            else                                             r_tmo <= r_tmo + c_tmo_w'(1);
            if (w_fall) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_data_s) begin
                            r_bit_cnt <= 3'd0;
                            r_shift   <= 8'h00;
                        end
                    end
                    S_DATA: begin
                        r_shift   <= {w_data_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    S_PARITY: r_parity <= w_data_s;
                    default:  ;
                endcase
            end
        end
    end

    // Registered result pulses and make/break key tracking.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_scan       <= 8'h00;
            r_scan_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_key        <= 8'h00;
            r_key_load   <= 1'b0;
            r_held       <= 8'h00;
            r_ext_pend   <= 1'b0;
            r_brk_pend   <= 1'b0;
        end else begin
            r_scan_valid <= w_good;
            r_frame_err  <= w_bad;
            r_key_load   <= 1'b0;
            if (w_bad) begin
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
            end else if (w_good) begin
                r_scan <= r_shift;
                if (r_shift == c_ext) begin
                    r_ext_pend <= 1'b1;
                end else if (r_shift == c_brk) begin
                    r_brk_pend <= 1'b1;
                end else begin
                    r_ext_pend <= 1'b0;
                    r_brk_pend <= 1'b0;
                    if (r_ext_pend) begin
                        // Extended keys are not mapped.
                    end else if (r_brk_pend) begin
                        if (r_shift == r_held) begin
                            r_held     <= 8'h00;
                            r_key      <= 8'h00;
                            r_key_load <= 1'b1;
                        end
                    end else begin
                        r_held     <= r_shift;
                        r_key      <= r_shift;
                        r_key_load <= 1'b1;
                    end
                end
            end
        end
    end

    assign scan_o       = r_scan;
    assign scan_valid_o = r_scan_valid;
    assign frame_err_o  = r_frame_err;
    assign key_o        = r_key;
    assign key_load_o   = r_key_load;
    assign busy_o       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_kbd_rx
//  Description : Self-checking bench for ps2_kbd_rx with a byte-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_rx;

    localparam int SYNC    = 2;
    localparam int TMO     = 200;
    localparam int HALF    = 20;

    logic       clk;
    logic       reset_i;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scan_o;
    logic       scan_valid_o;
    logic       frame_err_o;
    logic [7:0] key_o;
    logic       key_load_o;
    logic       busy_o;

    ps2_kbd_rx #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .ps2_clk_i    (ps2_clk),
        .ps2_data_i   (ps2_data),
        .scan_o       (scan_o),
        .scan_valid_o (scan_valid_o),
        .frame_err_o  (frame_err_o),
        .key_o        (key_o),
        .key_load_o   (key_load_o),
        .busy_o       (busy_o)
    );

    typedef struct {
        bit         err;
        logic [7:0] scan;
        bit         load;
        logic [7:0] key;
        longint     due;
        bit         timed;
    } ev_t;

    ev_t        q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    longint     cyc      = 0;
    int         n_valid  = 0;
    int         n_err    = 0;
    int         n_load   = 0;

    // Model state: byte-level key tracking plus the expected visible outputs.
    bit         m_ext    = 0;
    bit         m_brk    = 0;
    logic [7:0] m_held   = 8'h00;
    logic [7:0] cur_scan = 8'h00;
    logic [7:0] cur_key  = 8'h00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected outcome of one received (or aborted) frame.
    function automatic void push_event(input logic [7:0] b, input bit ok, input bit timed, input longint due);
        ev_t e;
        e.err = !ok; e.scan = b; e.load = 0; e.key = 8'h00; e.due = due; e.timed = timed;
        if (!ok) begin
            m_ext = 0; m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            if (m_ext) begin
                // extended code: nothing loads
            end else if (m_brk) begin
                if (b == m_held) begin
                    m_held = 8'h00; e.load = 1; e.key = 8'h00;
                end
            end else begin
                m_held = b; e.load = 1; e.key = b;
            end
            m_ext = 0; m_brk = 0;
        end
        q.push_back(e);
    endfunction

    // Per-cycle compare of the DUT outputs against the model.
    initial forever begin
        ev_t e;
        @(negedge clk);
        if (!reset_i) begin
            chk("valid_err_exclusive", {31'd0, scan_valid_o & frame_err_o}, 0);
            chk("load_without_valid", {31'd0, key_load_o & ~scan_valid_o}, 0);
            if (scan_valid_o) n_valid++;
            if (frame_err_o)  n_err++;
            if (key_load_o)   n_load++;
            if (scan_valid_o || frame_err_o) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("result_kind", {31'd0, frame_err_o}, {31'd0, e.err});
                    chk("busy_at_result", {31'd0, busy_o}, 0);
                    if (!e.timed) chk("result_latency", 32'(cyc - e.due), SYNC + 1);
                    if (!e.err) begin
                        cur_scan = e.scan;
                        if (e.load) cur_key = e.key;
                        chk("key_load", {31'd0, key_load_o}, {31'd0, e.load});
                    end
                end
            end
            chk("scan_o", {24'd0, scan_o}, {24'd0, cur_scan});
            chk("key_o", {24'd0, key_o}, {24'd0, cur_key});
        end
    end

    // Drive nbits of a frame (start, 8 data LSB-first, parity, stop).
    task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                        input int nbits, input bit push, input int gap);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            repeat (HALF) @(posedge clk);
            #1;
            ps2_clk = 1'b0;
            if (push && i == nbits - 1)
                push_event(b, !(bad_par || bad_stop) && nbits == 11, nbits != 11, cyc);
            repeat (HALF) @(posedge clk);
            #1;
            if (i == 3) chk("busy_mid_frame", {31'd0, busy_o}, 1);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (gap) @(posedge clk);
        #1;
        if (push) begin
            chk("result_seen", q.size(), 0);
            q.delete();
            chk("busy_idle", {31'd0, busy_o}, 0);
        end
    endtask

    task automatic good(input logic [7:0] b);
        send(b, 1'b0, 1'b0, 11, 1'b1, 3 * HALF);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 reset_i = 1'b1;
        @(posedge clk);
        #1;
        m_ext = 0; m_brk = 0; m_held = 8'h00; cur_scan = 8'h00; cur_key = 8'h00;
        q.delete();
        reset_i = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_scan"}, {24'd0, scan_o}, 0);
        chk({tag, "_key"}, {24'd0, key_o}, 0);
        chk({tag, "_ctl"}, {28'd0, scan_valid_o, frame_err_o, key_load_o, busy_o}, 0);
    endtask

    initial begin
        int v0, l0, e0;
        logic [7:0] pool [0:6];
        reset_i  = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(posedge clk);
        #1 reset_i = 1'b0;
        chk_all_zero("reset");

        // Single make code.
        l0 = n_load;
        good(8'h1C);
        chk("lit_scan_1C", {24'd0, scan_o}, 32'h1C);
        chk("lit_key_1C", {24'd0, key_o}, 32'h1C);
        chk("lit_model_key_1C", {24'd0, cur_key}, 32'h1C);
        chk("lit_load_once", n_load - l0, 1);

        // Make then break.
        v0 = n_valid; l0 = n_load;
        good(8'h1C); good(8'hF0); good(8'h1C);
        chk("lit_valid_x3", n_valid - v0, 3);
        chk("lit_load_x2", n_load - l0, 2);
        chk("lit_key_released", {24'd0, key_o}, 0);
        chk("lit_model_held", {24'd0, m_held}, 0);

        // Parity error.
        v0 = n_valid; e0 = n_err;
        send(8'h1C, 1'b1, 1'b0, 11, 1'b1, 3 * HALF);
        chk("lit_parity_err", n_err - e0, 1);
        chk("lit_parity_novalid", n_valid - v0, 0);
        chk("lit_parity_scan", {24'd0, scan_o}, 32'h1C);

        // Stop-bit error.
        e0 = n_err;
        send(8'h55, 1'b0, 1'b1, 11, 1'b1, 3 * HALF);
        chk("lit_stop_err", n_err - e0, 1);

        // Timeout after start + 4 data bits, then recovery.
        e0 = n_err;
        send(8'hA5, 1'b0, 1'b0, 5, 1'b1, TMO + 10);
        chk("lit_timeout_err", n_err - e0, 1);
        good(8'h32);
        chk("lit_scan_32", {24'd0, scan_o}, 32'h32);

        // Extended make and unmatched break leave the held key alone.
        good(8'h1C);
        v0 = n_valid; l0 = n_load;
        good(8'hE0); good(8'h75); good(8'hF0); good(8'h2B);
        chk("lit_valid_x4", n_valid - v0, 4);
        chk("lit_noload", n_load - l0, 0);
        chk("lit_key_kept", {24'd0, key_o}, 32'h1C);

        // Reset in the middle of a frame.
        e0 = n_err;
        send(8'h1C, 1'b0, 1'b0, 6, 1'b0, 2);
        pulse_reset();
        chk_all_zero("midreset");
        repeat (TMO + 50) @(posedge clk);
        #1;
        chk("lit_midreset_noerr", n_err - e0, 0);
        good(8'h1C);
        chk("lit_after_reset_key", {24'd0, key_o}, 32'h1C);

        // Randomised traffic.
        pool = '{8'h1C, 8'h32, 8'h2B, 8'hE0, 8'hF0, 8'h75, 8'h1C};
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            int sel;
            sel = $urandom_range(0, 7);
            b = (sel == 7) ? 8'($urandom_range(0, 255)) : pool[sel];
            sel = $urandom_range(0, 9);
            send(b, sel == 0, sel == 1, 11, 1'b1, 3 * HALF);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end expected end before time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
